eth_fcs_tx: RTL
===============

// Module: eth_fcs_tx
// PURPOSE
// - Downstream of the UDP header-prepend stage. Takes complete Ethernet frames (DA..payload, no FCS) on 32-bit AXI-Stream.
// - Optionally zero-pads each frame to the 60-byte minimum.
// - Appends the IEEE 802.3 CRC-32 FCS. Output feeds the MAC/PHY TX interface.
// PARAMETERS
// - AXIS_DATA_WIDTH  32  stream width; only 32 is supported (elaboration error otherwise)
// - MIN_FRAME_BYTES  60  minimum pre-FCS frame length; used only when ETH_PAD_EN is defined
// PORTS
// - clk            in   1   clock, all logic on rising edge
// - rst            in   1   synchronous, active-high reset
// - s_axis_tdata   in   32  frame bytes; byte n of a beat is in [8n+7:8n] (byte 0 first on the wire)
// - s_axis_tkeep   in   4   all-ones on non-last beats; contiguous from bit 0 on last beat (4'b0001/0011/0111/1111)
// - s_axis_tvalid  in   1   input beat valid
// - s_axis_tready  out  1   input beat accepted when tvalid&&tready
// - s_axis_tlast   in   1   last beat of frame
// - m_axis_tdata   out  32  frame + pad + FCS, same byte order
// - m_axis_tkeep   out  4   contiguous from bit 0; all-ones except possibly the final beat
// - m_axis_tvalid  out  1   output beat valid
// - m_axis_tready  in   1   downstream accept
// - m_axis_tlast   out  1   final beat (carries the last FCS byte)
// BEHAVIOUR
// - Reset values: m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, m_axis_tkeep=0, s_axis_tready=0.
//   Reset also sets state=PASS, crc=32'hFFFFFFFF, byte_cnt=0.
// - Reset mid-frame: the partial frame is dropped and the output beat is cleared. No FCS is emitted.
//   The next accepted beat starts a new frame.
// - Output register: single output stage. A beat is loaded when !m_axis_tvalid || m_axis_tready.
//   Data latency is 1 cycle. Output must hold stable while tvalid && !tready.
// - s_axis_tready = (state==PASS) && (!m_axis_tvalid || m_axis_tready).
// - CRC-32: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, per-byte LSB-first update over kept bytes only.
//   Pad bytes are included in the CRC. FCS = ~crc, sent as byte 0 = FCS[7:0] ... byte 3 = FCS[31:24].
// - byte_cnt: 16 bits, counts pre-FCS bytes, saturates at 16'hFFFF, cleared after each frame's FCS.
// - State PASS: forward accepted beats unchanged, tlast=0, update crc and byte_cnt.
//   On the s_axis_tlast beat with k kept bytes:
//   - If padding is needed (ETH_PAD_EN only, byte_cnt+k < MIN_FRAME_BYTES):
//     - zero-fill the rest of the beat (tkeep=4'hF) and go to PAD.
//   - Else if k==4: go to FCS_FULL.
//   - Else: fill bytes k..3 with the first 4-k FCS bytes (tkeep=4'hF), store the remaining k bytes, go to FCS_TAIL.
// - State PAD: emit 4'hF zero beats until byte_cnt==MIN_FRAME_BYTES, then go to FCS_FULL.
//   MIN_FRAME_BYTES must be a multiple of 4.
// - State FCS_FULL: emit the 4 FCS bytes, tkeep=4'hF, tlast=1. Then reset crc/byte_cnt and go to PASS.
// - State FCS_TAIL: emit the remaining k FCS bytes in bytes 0..k-1, tkeep = lower k ones, tlast=1.
//   Then reset crc/byte_cnt and go to PASS.
// - Back-to-back frames: the first beat of the next frame may be accepted in the cycle after the tlast output beat is loaded.
//   There are no bubbles beyond the PAD/FCS beats.
// - Non-contiguous tkeep or a non-full non-last beat is a protocol violation. Flag it with an assertion; output is undefined.
// CONFIGURATION
// - ETH_PAD_EN defined: frames shorter than MIN_FRAME_BYTES are zero-padded before the FCS, so output is >= MIN_FRAME_BYTES+4 bytes.
// - ETH_PAD_EN undefined: no padding. PAD state and MIN_FRAME_BYTES are unused. Output length = input length + 4.
// TESTING
// - No ETH_PAD_EN. Input "123456789" = 32'h34333231, 32'h38373635, 32'h00000039 (tkeep 0001, tlast).
//   Expect beats 32'h34333231, 32'h38373635, 32'hF4392639 (tkeep F), 32'h000000CB (tkeep 0001, tlast). FCS=32'hCBF43926.
// - ETH_PAD_EN. 44-byte header-only frame (11 beats). Expect 11 data beats, 4 zero pad beats, 1 FCS beat tlast: 16 beats / 64 bytes.
//   FCS equals the reference CRC computed over the 60 bytes.
// - Backpressure: m_axis_tready toggled pseudo-randomly 50% on a 100-byte frame.
//   Output beat sequence is identical to the tready=1 run. No beat is changed while stalled.
// - Back-to-back: three frames with last-beat k=1,2,4 and continuous tvalid.
//   Each frame gets a correct FCS, the tkeep/tlast pattern matches the k rules, and s_axis_tready deasserts only during FCS/PAD beats.
// - Reset mid-frame: assert rst for 1 cycle after 5 beats of a frame, then send the 9-byte vector.
//   Expect no tlast from the aborted frame, m_axis_tvalid=0 the cycle after reset, and correct FCS 32'hCBF43926 on the new frame.

Source files
------------

// File: rtl/eth_fcs_tx.sv
// rtl/eth_fcs_tx.sv - Ethernet FCS appender on 32-bit AXI-Stream, optional minimum-length zero padding
// Optional feature macro: ETH_PAD_EN (zero-pad frames to MIN_FRAME_BYTES before the FCS)
module eth_fcs_tx #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int MIN_FRAME_BYTES = 60
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [AXIS_DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic                         s_axis_tlast,
  output logic [AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [AXIS_DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic                         m_axis_tlast
);

  if (AXIS_DATA_WIDTH != 32) begin : g_bad_width
    $error("eth_fcs_tx: only AXIS_DATA_WIDTH=32 is supported");
  end
  if ((MIN_FRAME_BYTES % 4) != 0 || MIN_FRAME_BYTES > 65535) begin : g_bad_min
    $error("eth_fcs_tx: MIN_FRAME_BYTES must be a multiple of 4 below 65536");
  end

`ifdef ETH_PAD_EN
  localparam logic [15:0] MIN_CNT = 16'(MIN_FRAME_BYTES);
`endif

  typedef enum logic [1:0] {PASS, PAD, FCS_FULL, FCS_TAIL} state_t;

  state_t      state, state_n;
  logic [31:0] crc, crc_n, crc_in;
  logic [15:0] byte_cnt, cnt_n, cnt_in;
  logic [31:0] tail_data, tail_data_n;
  logic [3:0]  tail_keep, tail_keep_n;
  logic [31:0] data_n, beat, fcs_sh;
  logic [3:0]  keep_n;
  logic        valid_n, last_n, load;
  logic [2:0]  kept;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ b[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_beat(input logic [31:0] c, input logic [31:0] d,
                                           input logic [3:0] k);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++)
      if (k[i]) r = crc_byte(r, d[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [15:0] cnt_add(input logic [15:0] c, input logic [2:0] n);
    logic [16:0] s;
    s = {1'b0, c} + {14'b0, n};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  assign load          = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !rst && (state == PASS) && load;

  always_comb begin
    state_n     = state;
    crc_n       = crc;
    cnt_n       = byte_cnt;
    tail_data_n = tail_data;
    tail_keep_n = tail_keep;
    data_n      = m_axis_tdata;
    keep_n      = m_axis_tkeep;
    valid_n     = m_axis_tvalid;
    last_n      = m_axis_tlast;
    beat        = s_axis_tdata;
    fcs_sh      = '0;
    crc_in      = crc;
    cnt_in      = byte_cnt;
    case (s_axis_tkeep)
      4'b0001: kept = 3'd1;
      4'b0011: kept = 3'd2;
      4'b0111: kept = 3'd3;
      default: kept = 3'd4;
    endcase

    if (load) begin
      valid_n = 1'b0;
      last_n  = 1'b0;
      case (state)
        PASS: begin
          if (s_axis_tvalid) begin
            crc_in  = crc_beat(crc, s_axis_tdata, s_axis_tkeep);
            cnt_in  = cnt_add(byte_cnt, kept);
            fcs_sh  = ~crc_in;
            valid_n = 1'b1;
            keep_n  = s_axis_tkeep;
            crc_n   = crc_in;
            cnt_n   = cnt_in;
            if (s_axis_tlast) begin
`ifdef ETH_PAD_EN
              if (cnt_in < MIN_CNT) begin
                // Short frame: the unused lanes of this beat become the first pad bytes.
                for (int i = 0; i < 4; i++)
                  if (!s_axis_tkeep[i]) beat[8*i +: 8] = 8'h00;
                keep_n  = 4'hF;
                crc_n   = crc_beat(crc, beat, 4'hF);
                cnt_n   = cnt_add(byte_cnt, 3'd4);
                state_n = (cnt_n >= MIN_CNT) ? FCS_FULL : PAD;
              end else
`endif
              if (s_axis_tkeep == 4'hF) begin
                state_n = FCS_FULL;
              end else begin
                // Leading FCS bytes fill the free lanes; the leftover k bytes shift down for the tail beat.
                for (int i = 0; i < 4; i++)
                  if (!s_axis_tkeep[i]) begin
                    beat[8*i +: 8] = fcs_sh[7:0];
                    fcs_sh         = fcs_sh >> 8;
                  end
                keep_n      = 4'hF;
                tail_data_n = fcs_sh;
                tail_keep_n = s_axis_tkeep;
                state_n     = FCS_TAIL;
              end
            end
            data_n = beat;
          end
        end
`ifdef ETH_PAD_EN
        PAD: begin
          data_n  = '0;
          keep_n  = 4'hF;
          valid_n = 1'b1;
          crc_n   = crc_beat(crc, 32'h0, 4'hF);
          cnt_n   = cnt_add(byte_cnt, 3'd4);
          if (cnt_n >= MIN_CNT) state_n = FCS_FULL;
        end
`endif
        FCS_FULL: begin
          data_n  = ~crc;
          keep_n  = 4'hF;
          valid_n = 1'b1;
          last_n  = 1'b1;
          crc_n   = 32'hFFFFFFFF;
          cnt_n   = '0;
          state_n = PASS;
        end
        FCS_TAIL: begin
          data_n  = tail_data;
          keep_n  = tail_keep;
          valid_n = 1'b1;
          last_n  = 1'b1;
          crc_n   = 32'hFFFFFFFF;
          cnt_n   = '0;
          state_n = PASS;
        end
        default: state_n = PASS;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= PASS;
      crc           <= 32'hFFFFFFFF;
      byte_cnt      <= '0;
      tail_data     <= '0;
      tail_keep     <= '0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      state         <= state_n;
      crc           <= crc_n;
      byte_cnt      <= cnt_n;
      tail_data     <= tail_data_n;
      tail_keep     <= tail_keep_n;
      m_axis_tdata  <= data_n;
      m_axis_tkeep  <= keep_n;
      m_axis_tvalid <= valid_n;
      m_axis_tlast  <= last_n;
    end
  end

  a_keep_legal: assert property (@(posedge clk) disable iff (rst)
    (s_axis_tvalid && s_axis_tready) |->
      (s_axis_tlast ? (s_axis_tkeep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111})
                    : (s_axis_tkeep == 4'b1111)));

endmodule
